// File: rtl/clock_gate_ctrl_pkg.sv
// ============================================================================
// clock_gate_ctrl_pkg : state encodings and counter sizing for clock_gate_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package clock_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Width of the shared wake/hold down-counter; never narrower than 1 bit.
  function automatic int cnt_width(input int wake, input int hold);
    int m;
    int w;
    m = (wake > hold) ? wake : hold;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CNT_W = cnt_width(2, 16);

endpackage

`default_nettype wire

// File: rtl/clock_gate_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter with synchronous clear priority
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/clock_gate_ctrl.sv
// ============================================================================
// clock_gate_ctrl : request-merging sequencer for a BUFGCE clock enable
// Rev 1.0
// ============================================================================
`default_nettype none

module clock_gate_ctrl
  import clock_gate_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              force_on,
  input  logic              clear_stats,
  output logic              gate_en,
  output logic [N_REQ-1:0]  ack,
  output logic [1:0]        state,
  output logic [STAT_W-1:0] on_cycles
);

  localparam int CW = cnt_width(WAKE_CYCLES, HOLD_CYCLES);
  // Counter runs from LOAD down to 0, giving exactly *_CYCLES cycles in the state.
  localparam logic [CW-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CW'(WAKE_CYCLES - 1) : '0;
  localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             gate_en_q;
  logic             gate_en_d;
  logic [N_REQ-1:0] ack_q;
  logic [N_REQ-1:0] ack_d;
  logic             any_req;

  assign any_req = (|req) | force_on;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (any_req) begin
          if (WAKE_CYCLES == 0) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_WAKE;
            cnt_d   = WAKE_LOAD;
          end
        end
      end
      ST_WAKE: begin
        // The wake always completes, even if every requester has dropped.
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ON: begin
        if (!any_req) begin
          if (HOLD_CYCLES == 0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        // A request on the expiry cycle still wins over going OFF.
        if (any_req) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    gate_en_d = (state_d != ST_OFF);
    ack_d     = (state_d == ST_ON) ? req : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      gate_en_q <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gate_en_q <= gate_en_d;
      ack_q     <= ack_d;
    end
  end

  sat_counter #(
    .WIDTH (STAT_W)
  ) u_on_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (gate_en_q),
    .clear (clear_stats),
    .count (on_cycles)
  );

  assign gate_en = gate_en_q;
  assign ack     = ack_q;
  assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_gate_ctrl.sv
// ============================================================================
// tb_clock_gate_ctrl : scoreboard bench for clock_gate_ctrl (three configs)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clock_gate_ctrl;

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: WAKE=2, HOLD=16, STAT_W=32
  logic        rst_a = 1'b1, force_a = 1'b0, clr_a = 1'b0;
  logic [3:0]  req_a = '0;
  logic        gate_a;
  logic [3:0]  ack_a;
  logic [1:0]  state_a;
  logic [31:0] oc_a;
  // DUT B: WAKE=0, HOLD=0, STAT_W=8
  logic        rst_b = 1'b1, force_b = 1'b0, clr_b = 1'b0;
  logic [3:0]  req_b = '0;
  logic        gate_b;
  logic [3:0]  ack_b;
  logic [1:0]  state_b;
  logic [7:0]  oc_b;
  // DUT C: WAKE=2, HOLD=16, STAT_W=4
  logic        rst_c = 1'b1, force_c = 1'b0, clr_c = 1'b0;
  logic [3:0]  req_c = '0;
  logic        gate_c;
  logic [3:0]  ack_c;
  logic [1:0]  state_c;
  logic [3:0]  oc_c;

  clock_gate_ctrl #(.N_REQ(4), .WAKE_CYCLES(2), .HOLD_CYCLES(16), .STAT_W(32)) u_dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .force_on(force_a), .clear_stats(clr_a),
    .gate_en(gate_a), .ack(ack_a), .state(state_a), .on_cycles(oc_a));

  clock_gate_ctrl #(.N_REQ(4), .WAKE_CYCLES(0), .HOLD_CYCLES(0), .STAT_W(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .force_on(force_b), .clear_stats(clr_b),
    .gate_en(gate_b), .ack(ack_b), .state(state_b), .on_cycles(oc_b));

  clock_gate_ctrl #(.N_REQ(4), .WAKE_CYCLES(2), .HOLD_CYCLES(16), .STAT_W(4)) u_dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .force_on(force_c), .clear_stats(clr_c),
    .gate_en(gate_c), .ack(ack_c), .state(state_c), .on_cycles(oc_c));

  typedef struct {
    int          cyc;
    int          dut;
    logic [1:0]  st;
    logic        ge;
    logic [3:0]  ack;
    bit          chk_oc;
    logic [31:0] oc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push_exp(input int c, input int d, input logic [1:0] st, input logic ge,
                          input logic [3:0] ak, input bit chk, input logic [31:0] oc,
                          input string nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.st = st; e.ge = ge; e.ack = ak;
    e.chk_oc = chk; e.oc = oc; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  // Monitor: every negedge, retire the scoreboard entries due this cycle.
  logic [1:0]  mon_st;
  logic        mon_ge;
  logic [3:0]  mon_ak;
  logic [31:0] mon_oc;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].dut)
          0: begin mon_st = state_a; mon_ge = gate_a; mon_ak = ack_a; mon_oc = oc_a; end
          1: begin mon_st = state_b; mon_ge = gate_b; mon_ak = ack_b; mon_oc = {24'd0, oc_b}; end
          default: begin mon_st = state_c; mon_ge = gate_c; mon_ak = ack_c; mon_oc = {28'd0, oc_c}; end
        endcase
        checks++;
        if (mon_st !== sb[i].st || mon_ge !== sb[i].ge || mon_ak !== sb[i].ack ||
            (sb[i].chk_oc && mon_oc !== sb[i].oc)) begin
          errors++;
          $display("FAIL %s @cyc %0d: got state=%0d gate_en=%b ack=%b on_cycles=%0d, want state=%0d gate_en=%b ack=%b on_cycles=%0d%s",
                   sb[i].name, cyc, mon_st, mon_ge, mon_ak, mon_oc,
                   sb[i].st, sb[i].ge, sb[i].ack, sb[i].oc, sb[i].chk_oc ? "" : "(unchecked)");
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  int base;

  initial begin
    push_exp(2, 0, S_OFF, 1'b0, 4'b0000, 1'b1, 32'd0, "reset_a");
    push_exp(2, 1, S_OFF, 1'b0, 4'b0000, 1'b1, 32'd0, "reset_b");
    push_exp(2, 2, S_OFF, 1'b0, 4'b0000, 1'b1, 32'd0, "reset_c");
    wait_until(3);
    checks++;
    if (state_a !== S_OFF || gate_a !== 1'b0 || ack_a !== 4'b0000 || oc_a !== 32'd0) begin
      errors++;
      $display("FAIL direct_reset_a: state=%0d gate_en=%b ack=%b on_cycles=%0d", state_a, gate_a, ack_a, oc_a);
    end
    checks++;
    if (state_b !== S_OFF || gate_b !== 1'b0 || ack_b !== 4'b0000 || oc_b !== 8'd0) begin
      errors++;
      $display("FAIL direct_reset_b: state=%0d gate_en=%b ack=%b on_cycles=%0d", state_b, gate_b, ack_b, oc_b);
    end
    checks++;
    if (state_c !== S_OFF || gate_c !== 1'b0 || ack_c !== 4'b0000 || oc_c !== 4'd0) begin
      errors++;
      $display("FAIL direct_reset_c: state=%0d gate_en=%b ack=%b on_cycles=%0d", state_c, gate_c, ack_c, oc_c);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Cold request and idle hold-off
    base = cyc;
    push_exp(base + 1,  0, S_WAKE, 1'b1, 4'b0000, 1'b1, 32'd0,  "cold_wake1");
    push_exp(base + 2,  0, S_WAKE, 1'b1, 4'b0000, 1'b0, 32'd0,  "cold_wake2");
    push_exp(base + 3,  0, S_ON,   1'b1, 4'b0001, 1'b1, 32'd2,  "cold_ack");
    push_exp(base + 6,  0, S_HOLD, 1'b1, 4'b0000, 1'b0, 32'd0,  "hold_enter");
    push_exp(base + 21, 0, S_HOLD, 1'b1, 4'b0000, 1'b0, 32'd0,  "hold_last");
    push_exp(base + 22, 0, S_OFF,  1'b0, 4'b0000, 1'b1, 32'd21, "hold_expire");
    push_exp(base + 30, 0, S_OFF,  1'b0, 4'b0000, 1'b1, 32'd21, "stats_frozen");
    req_a = 4'b0001;
    wait_until(base + 5);  req_a = 4'b0000;
    wait_until(base + 31);

    // Re-request in HOLD, expiry-cycle request, force_on, staggered acks, async reset
    base = cyc;
    push_exp(base + 3,  0, S_ON,   1'b1, 4'b0001, 1'b0, 32'd0, "rereq_on");
    push_exp(base + 10, 0, S_HOLD, 1'b1, 4'b0000, 1'b0, 32'd0, "rereq_hold");
    push_exp(base + 11, 0, S_ON,   1'b1, 4'b0100, 1'b0, 32'd0, "rereq_ack2");
    push_exp(base + 13, 0, S_HOLD, 1'b1, 4'b0000, 1'b0, 32'd0, "hold2_enter");
    push_exp(base + 28, 0, S_HOLD, 1'b1, 4'b0000, 1'b0, 32'd0, "hold2_expiry");
    push_exp(base + 29, 0, S_ON,   1'b1, 4'b1000, 1'b0, 32'd0, "expiry_req_wins");
    push_exp(base + 31, 0, S_HOLD, 1'b1, 4'b0000, 1'b0, 32'd0, "hold3_enter");
    push_exp(base + 32, 0, S_ON,   1'b1, 4'b0000, 1'b0, 32'd0, "force_on_noack");
    push_exp(base + 34, 0, S_ON,   1'b1, 4'b0001, 1'b0, 32'd0, "stagger_ack0");
    push_exp(base + 36, 0, S_ON,   1'b1, 4'b1001, 1'b0, 32'd0, "stagger_ack03");
    push_exp(base + 38, 0, S_ON,   1'b1, 4'b1000, 1'b0, 32'd0, "stagger_drop0");
    push_exp(base + 40, 0, S_ON,   1'b1, 4'b0000, 1'b0, 32'd0, "force_only");
    push_exp(base + 42, 0, S_HOLD, 1'b1, 4'b0000, 1'b0, 32'd0, "force_drop_hold");
    push_exp(base + 58, 0, S_OFF,  1'b0, 4'b0000, 1'b0, 32'd0, "force_hold_off");
    push_exp(base + 61, 0, S_WAKE, 1'b1, 4'b0000, 1'b0, 32'd0, "pre_rst_wake");
    push_exp(base + 62, 0, S_OFF,  1'b0, 4'b0000, 1'b1, 32'd0, "async_rst");
    push_exp(base + 64, 0, S_OFF,  1'b0, 4'b0000, 1'b1, 32'd0, "post_rst");
    req_a = 4'b0001;
    wait_until(base + 5);  req_a = 4'b0000;
    wait_until(base + 10); req_a = 4'b0100;
    wait_until(base + 12); req_a = 4'b0000;
    wait_until(base + 28); req_a = 4'b1000;
    wait_until(base + 30); req_a = 4'b0000;
    wait_until(base + 31); force_a = 1'b1;
    wait_until(base + 33); req_a = 4'b0001;
    wait_until(base + 35); req_a = 4'b1001;
    wait_until(base + 37); req_a = 4'b1000;
    wait_until(base + 39); req_a = 4'b0000;
    wait_until(base + 41); force_a = 1'b0;
    wait_until(base + 60); req_a = 4'b0001;
    wait_until(base + 62); rst_a = 1'b1;
    #1;
    checks++;
    if (state_a !== S_OFF || gate_a !== 1'b0 || ack_a !== 4'b0000 || oc_a !== 32'd0) begin
      errors++;
      $display("FAIL direct_async_rst: state=%0d gate_en=%b ack=%b on_cycles=%0d", state_a, gate_a, ack_a, oc_a);
    end
    wait_until(base + 63); rst_a = 1'b0; req_a = 4'b0000;
    wait_until(base + 65);

    // Zero wake/hold parameters
    base = cyc;
    push_exp(base + 1, 1, S_ON,  1'b1, 4'b0001, 1'b1, 32'd0, "zero_ack");
    push_exp(base + 2, 1, S_ON,  1'b1, 4'b0001, 1'b1, 32'd1, "zero_on");
    push_exp(base + 4, 1, S_OFF, 1'b0, 4'b0000, 1'b1, 32'd3, "zero_off");
    push_exp(base + 5, 1, S_OFF, 1'b0, 4'b0000, 1'b1, 32'd3, "zero_stay_off");
    req_b = 4'b0001;
    wait_until(base + 3); req_b = 4'b0000;
    wait_until(base + 6);

    // Statistics saturation and clear-with-increment
    base = cyc;
    push_exp(base + 10, 2, S_ON, 1'b1, 4'b0000, 1'b1, 32'd9,  "stats_count");
    push_exp(base + 21, 2, S_ON, 1'b1, 4'b0000, 1'b1, 32'd15, "stats_saturate");
    push_exp(base + 23, 2, S_ON, 1'b1, 4'b0000, 1'b1, 32'd0,  "stats_clear");
    push_exp(base + 24, 2, S_ON, 1'b1, 4'b0000, 1'b1, 32'd1,  "stats_restart");
    force_c = 1'b1;
    wait_until(base + 22); clr_c = 1'b1;
    wait_until(base + 23); clr_c = 1'b0;
    wait_until(base + 25); force_c = 1'b0;
    wait_until(base + 27);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked (due cyc %0d, now %0d)", sb[i].name, sb[i].cyc, cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
